// File: rtl/rocket_axi_rd_arbiter_pkg.sv
// Shared AXI constants, AR FSM state and requester indices for the Rocket AXI read arbiter.
// Grant policy of rocket_axi_rd_arbiter is selected by RD_ARB_ROUND_ROBIN_EN.
package rocket_axi_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int REQ_CORE  = 0;
    localparam int REQ_HOST  = 1;
    localparam int NUM_REQ   = 2;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_BUSY = 1'b1
    } ar_state_t;

    // Width-independent part of an AR request; ID and address are parameterised in the top.
    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic [3:0] cache;
        logic [2:0] prot;
    } ar_attr_t;

endpackage

// File: rtl/rocket_axi_rd_arbiter_rr.sv
// Two-way arbiter with a one-hot grant. RD_ARB_ROUND_ROBIN_EN selects round-robin;
// otherwise requester 0 has fixed priority and no pointer register exists.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

`ifdef RD_ARB_ROUND_ROBIN_EN
    // Index of the requester that wins the next tie.
    logic prio;

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11)
            grant[prio] = 1'b1;
        else
            grant = req;
    end

    always_ff @(posedge clk) begin
        if (rst)
            prio <= 1'b0;
        else if (advance)
            prio <= grant[0];
    end
`else
    logic unused_fixed;
    assign unused_fixed = &{1'b0, clk, rst, advance};

    always_comb begin
        grant = 2'b00;
        if (req[0])
            grant = 2'b01;
        else if (req[1])
            grant = 2'b10;
    end
`endif

endmodule

// File: rtl/rocket_axi_rd_arbiter.sv
// Shares one AXI4 read master between the core port (s0) and the host loader (s1).
// Grant policy: round-robin with RD_ARB_ROUND_ROBIN_EN defined, fixed s0 priority otherwise.
module rocket_axi_rd_arbiter
    import rocket_axi_pkg::*;
#(
    parameter int C_S_ID_WIDTH      = 5,
    parameter int C_ADDR_WIDTH      = 32,
    parameter int C_DATA_WIDTH      = 64,
    parameter int C_MAX_OUTSTANDING = 4
) (
    input  logic                    m_axi_aclk,
    input  logic                    m_axi_areset,

    input  logic [C_S_ID_WIDTH-1:0] s0_arid,
    input  logic [C_ADDR_WIDTH-1:0] s0_araddr,
    input  logic [7:0]              s0_arlen,
    input  logic [2:0]              s0_arsize,
    input  logic [1:0]              s0_arburst,
    input  logic [3:0]              s0_arcache,
    input  logic [2:0]              s0_arprot,
    input  logic                    s0_arvalid,
    output logic                    s0_arready,
    output logic [C_S_ID_WIDTH-1:0] s0_rid,
    output logic [C_DATA_WIDTH-1:0] s0_rdata,
    output logic [1:0]              s0_rresp,
    output logic                    s0_rlast,
    output logic                    s0_rvalid,
    input  logic                    s0_rready,

    input  logic [C_S_ID_WIDTH-1:0] s1_arid,
    input  logic [C_ADDR_WIDTH-1:0] s1_araddr,
    input  logic [7:0]              s1_arlen,
    input  logic [2:0]              s1_arsize,
    input  logic [1:0]              s1_arburst,
    input  logic [3:0]              s1_arcache,
    input  logic [2:0]              s1_arprot,
    input  logic                    s1_arvalid,
    output logic                    s1_arready,
    output logic [C_S_ID_WIDTH-1:0] s1_rid,
    output logic [C_DATA_WIDTH-1:0] s1_rdata,
    output logic [1:0]              s1_rresp,
    output logic                    s1_rlast,
    output logic                    s1_rvalid,
    input  logic                    s1_rready,

    output logic [C_S_ID_WIDTH:0]   m_axi_arid,
    output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,

    input  logic [C_S_ID_WIDTH:0]   m_axi_rid,
    input  logic [C_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int             CW    = $clog2(C_MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]  MAX_O = CW'(C_MAX_OUTSTANDING);

    ar_state_t                       ar_state;
    ar_attr_t                        ar_attr_q;
    logic [NUM_REQ-1:0][CW-1:0]      outst;
    logic [NUM_REQ-1:0]              arvalid_vec;
    logic [NUM_REQ-1:0]              elig;
    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ-1:0]              grant;
    logic [NUM_REQ-1:0]              inc;
    logic [NUM_REQ-1:0]              dec;
    logic                            grant_any;
    logic                            ar_owner;
    logic                            r_sel;
    logic                            ar_hs;
    logic                            r_last_hs;

    // ---------------- AR arbitration ----------------
    assign arvalid_vec = {s1_arvalid, s0_arvalid};

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = arvalid_vec[i] && (outst[i] < MAX_O);
    end

    // Requests are only offered while IDLE so arready never depends on m_axi_arready.
    assign req       = (ar_state == AR_IDLE) ? elig : '0;
    assign grant_any = |grant;

    rr_arbiter_2 u_arb (
        .clk     (m_axi_aclk),
        .rst     (m_axi_areset),
        .req     (req),
        .advance (grant_any),
        .grant   (grant)
    );

    assign s0_arready = grant[REQ_CORE];
    assign s1_arready = grant[REQ_HOST];

    // ---------------- AR register / FSM ----------------
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            ar_state      <= AR_IDLE;
            m_axi_arvalid <= 1'b0;
            m_axi_arid    <= '0;
            m_axi_araddr  <= '0;
            ar_attr_q     <= '0;
        end else begin
            case (ar_state)
                AR_IDLE: begin
                    if (grant_any) begin
                        ar_state      <= AR_BUSY;
                        m_axi_arvalid <= 1'b1;
                        if (grant[REQ_HOST]) begin
                            m_axi_arid   <= {1'b1, s1_arid};
                            m_axi_araddr <= s1_araddr;
                            ar_attr_q    <= '{len: s1_arlen, size: s1_arsize, burst: s1_arburst,
                                              cache: s1_arcache, prot: s1_arprot};
                        end else begin
                            m_axi_arid   <= {1'b0, s0_arid};
                            m_axi_araddr <= s0_araddr;
                            ar_attr_q    <= '{len: s0_arlen, size: s0_arsize, burst: s0_arburst,
                                              cache: s0_arcache, prot: s0_arprot};
                        end
                    end
                end
                AR_BUSY: begin
                    if (m_axi_arready) begin
                        ar_state      <= AR_IDLE;
                        m_axi_arvalid <= 1'b0;
                    end
                end
                default: begin
                    ar_state      <= AR_IDLE;
                    m_axi_arvalid <= 1'b0;
                end
            endcase
        end
    end

    assign m_axi_arlen   = ar_attr_q.len;
    assign m_axi_arsize  = ar_attr_q.size;
    assign m_axi_arburst = ar_attr_q.burst;
    assign m_axi_arcache = ar_attr_q.cache;
    assign m_axi_arprot  = ar_attr_q.prot;

    // ---------------- R routing (purely combinational) ----------------
    assign r_sel        = m_axi_rid[C_S_ID_WIDTH];
    assign m_axi_rready = r_sel ? s1_rready : s0_rready;

    assign s0_rvalid = m_axi_rvalid & ~r_sel;
    assign s1_rvalid = m_axi_rvalid &  r_sel;
    assign s0_rid    = m_axi_rid[C_S_ID_WIDTH-1:0];
    assign s1_rid    = m_axi_rid[C_S_ID_WIDTH-1:0];
    assign s0_rdata  = m_axi_rdata;
    assign s1_rdata  = m_axi_rdata;
    assign s0_rresp  = m_axi_rresp;
    assign s1_rresp  = m_axi_rresp;
    assign s0_rlast  = m_axi_rlast;
    assign s1_rlast  = m_axi_rlast;

    // ---------------- Outstanding-burst counters ----------------
    assign ar_owner  = m_axi_arid[C_S_ID_WIDTH];
    assign ar_hs     = (ar_state == AR_BUSY) && m_axi_arvalid && m_axi_arready;
    assign r_last_hs = m_axi_rvalid && m_axi_rready && m_axi_rlast;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            inc[i] = ar_hs     && (ar_owner == 1'(i));
            dec[i] = r_last_hs && (r_sel    == 1'(i));
        end
    end

    // Saturating at both ends; a same-cycle inc and dec cancel.
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            outst <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (inc[i] && !dec[i] && (outst[i] != MAX_O))
                    outst[i] <= outst[i] + CW'(1);
                else if (dec[i] && !inc[i] && (outst[i] != '0))
                    outst[i] <= outst[i] - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rocket_axi_rd_arbiter.sv
// Directed self-checking bench for rocket_axi_rd_arbiter; expectations follow the
// RD_ARB_ROUND_ROBIN_EN setting of the build.
module tb_rocket_axi_rd_arbiter;
    import rocket_axi_pkg::*;

    localparam int IDW = 5;
    localparam int AW  = 32;
    localparam int DW  = 64;

    logic clk = 1'b0;
    logic rst;

    logic [IDW-1:0] s0_arid, s1_arid, s0_rid, s1_rid;
    logic [AW-1:0]  s0_araddr, s1_araddr;
    logic [7:0]     s0_arlen, s1_arlen;
    logic [2:0]     s0_arsize, s1_arsize, s0_arprot, s1_arprot;
    logic [1:0]     s0_arburst, s1_arburst, s0_rresp, s1_rresp;
    logic [3:0]     s0_arcache, s1_arcache;
    logic           s0_arvalid, s1_arvalid, s0_arready, s1_arready;
    logic [DW-1:0]  s0_rdata, s1_rdata;
    logic           s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready, s1_rready;

    logic [IDW:0]   m_arid, m_rid;
    logic [AW-1:0]  m_araddr;
    logic [7:0]     m_arlen;
    logic [2:0]     m_arsize, m_arprot;
    logic [1:0]     m_arburst, m_rresp;
    logic [3:0]     m_arcache;
    logic           m_arvalid, m_arready;
    logic [DW-1:0]  m_rdata;
    logic           m_rlast, m_rvalid, m_rready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rocket_axi_rd_arbiter #(
        .C_S_ID_WIDTH(IDW), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_MAX_OUTSTANDING(4)
    ) dut (
        .m_axi_aclk(clk), .m_axi_areset(rst),
        .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
        .s0_arburst(s0_arburst), .s0_arcache(s0_arcache), .s0_arprot(s0_arprot),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
        .s1_arburst(s1_arburst), .s1_arcache(s1_arcache), .s1_arprot(s1_arprot),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
        .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst), .m_axi_arcache(m_arcache),
        .m_axi_arprot(m_arprot), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
        .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
        .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic g;
        rst = 1'b1;
        s0_arid = '0; s0_araddr = '0; s0_arlen = '0; s0_arsize = 3'd3; s0_arburst = AXI_BURST_INCR;
        s0_arcache = 4'h2; s0_arprot = 3'd0; s0_arvalid = 1'b0; s0_rready = 1'b0;
        s1_arid = '0; s1_araddr = '0; s1_arlen = '0; s1_arsize = 3'd3; s1_arburst = AXI_BURST_INCR;
        s1_arcache = 4'h2; s1_arprot = 3'd2; s1_arvalid = 1'b0; s1_rready = 1'b0;
        m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = AXI_RESP_OKAY;
        m_rlast = 1'b0; m_rvalid = 1'b0;
        do_reset();

        // Reset state
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_s0_arready", s0_arready, 0);
        chk("rst_s1_arready", s1_arready, 0);
        chk("rst_state", dut.ar_state, AR_IDLE);
        chk("rst_outst0", dut.outst[0], 0);
        chk("rst_outst1", dut.outst[1], 0);

        // Single s0 read: 4 beats routed to s0 only
        s0_arvalid = 1'b1; s0_arid = 5'h03; s0_araddr = 32'h1000; s0_arlen = 8'd3;
        #1;
        chk("t1_s0_arready", s0_arready, 1);
        chk("t1_s1_arready", s1_arready, 0);
        tick();
        s0_arvalid = 1'b0;
        chk("t1_arvalid", m_arvalid, 1);
        chk("t1_arid", m_arid, 6'h03);
        chk("t1_araddr", m_araddr, 32'h1000);
        chk("t1_arlen", m_arlen, 3);
        chk("t1_arburst", m_arburst, AXI_BURST_INCR);
        chk("t1_state", dut.ar_state, AR_BUSY);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        chk("t1_arvalid_drop", m_arvalid, 0);
        chk("t1_outst0_inc", dut.outst[0], 1);
        s0_rready = 1'b1; s1_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_rvalid = 1'b1; m_rid = 6'h03; m_rdata = 64'hA5A5_0000_0000_0000 + 64'(i);
            m_rlast = (i == 3);
            #1;
            chk("t1_s0_rvalid", s0_rvalid, 1);
            chk("t1_s1_rvalid", s1_rvalid, 0);
            chk("t1_s0_rid", s0_rid, 5'h03);
            chk("t1_s0_rdata", s0_rdata, 64'hA5A5_0000_0000_0000 + 64'(i));
            chk("t1_outst0_hold", dut.outst[0], 1);
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        chk("t1_outst0_dec", dut.outst[0], 0);

        // Contention with both requesters valid every cycle
        do_reset();
        s0_arvalid = 1'b1; s0_arid = 5'h04; s1_arvalid = 1'b1; s1_arid = 5'h07;
        m_arready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef RD_ARB_ROUND_ROBIN_EN
            g = 1'(k % 2);
`else
            g = 1'b0;
`endif
            chk("t2_s0_arready", s0_arready, {63'd0, ~g});
            chk("t2_s1_arready", s1_arready, {63'd0, g});
            tick();
            chk("t2_arvalid", m_arvalid, 1);
            chk("t2_arid", m_arid, g ? 6'h27 : 6'h04);
            chk("t2_busy_s0_arready", s0_arready, 0);
            chk("t2_busy_s1_arready", s1_arready, 0);
            tick();
        end
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
`ifdef RD_ARB_ROUND_ROBIN_EN
        chk("t2_outst0", dut.outst[0], 2);
        chk("t2_outst1", dut.outst[1], 2);
`else
        chk("t2_outst0", dut.outst[0], 4);
        chk("t2_outst1", dut.outst[1], 0);
`endif

        // s1 fills its outstanding budget, then waits for an rlast
        do_reset();
        s1_arvalid = 1'b1; s1_arid = 5'h0a; m_arready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("t3_s1_arready", s1_arready, 1);
            tick();
            chk("t3_arvalid", m_arvalid, 1);
            tick();
        end
        chk("t3_outst1_full", dut.outst[1], 4);
        chk("t3_s1_arready_blocked", s1_arready, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_wait_arvalid", m_arvalid, 0);
            chk("t3_wait_s1_arready", s1_arready, 0);
        end
        m_rvalid = 1'b1; m_rid = 6'h2a; m_rlast = 1'b1; s1_rready = 1'b1;
        #1;
        chk("t3_s1_rvalid", s1_rvalid, 1);
        chk("t3_m_rready", m_rready, 1);
        chk("t3_s1_arready_still0", s1_arready, 0);
        tick();
        m_rvalid = 1'b0;
        chk("t3_outst1_dec", dut.outst[1], 3);
        chk("t3_s1_arready_free", s1_arready, 1);
        tick();
        // AR handshake and rlast for s1 in the same cycle
        m_rvalid = 1'b1;
        #1;
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0; s1_arvalid = 1'b0;
        chk("t3_outst1_cancel", dut.outst[1], 3);
        chk("t3_state", dut.ar_state, AR_IDLE);

        // AR stall: payload stable, no grants while BUSY
        m_arready = 1'b0;
        s0_arvalid = 1'b1; s0_arid = 5'h1f; s0_araddr = 32'hDEADBEE0; s0_arlen = 8'd7;
        s1_arvalid = 1'b1;
        #1;
        chk("t4_s0_arready", s0_arready, 1);
        chk("t4_s1_arready", s1_arready, 0);
        tick();
        s0_arvalid = 1'b0; s0_araddr = 32'h0BAD_0000; s0_arlen = 8'd1;
        for (int k = 0; k < 10; k++) begin
            chk("t4_arvalid", m_arvalid, 1);
            chk("t4_arid", m_arid, 6'h1f);
            chk("t4_araddr", m_araddr, 32'hDEADBEE0);
            chk("t4_arlen", m_arlen, 7);
            chk("t4_s0_arready", s0_arready, 0);
            chk("t4_s1_arready", s1_arready, 0);
            tick();
        end
        s1_arvalid = 1'b0; m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        chk("t4_arvalid_drop", m_arvalid, 0);
        chk("t4_outst0", dut.outst[0], 1);

        // R back-pressure on s1
        m_rvalid = 1'b1; m_rid = 6'h21; m_rlast = 1'b1; s1_rready = 1'b0; s0_rready = 1'b1;
        #1;
        chk("t5_m_rready_low", m_rready, 0);
        chk("t5_s0_rvalid", s0_rvalid, 0);
        chk("t5_s1_rvalid", s1_rvalid, 1);
        chk("t5_s1_rid", s1_rid, 5'h01);
        tick();
        chk("t5_outst1_hold", dut.outst[1], 3);
        s1_rready = 1'b1;
        #1;
        chk("t5_m_rready_high", m_rready, 1);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        chk("t5_outst1_dec", dut.outst[1], 2);

        // Reset while BUSY with outst_0=2
        do_reset();
        s0_arvalid = 1'b1; s0_arid = 5'h02; m_arready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            tick();
        end
        m_arready = 1'b0;
        tick();
        s0_arvalid = 1'b0;
        chk("t6_state_busy", dut.ar_state, AR_BUSY);
        chk("t6_outst0", dut.outst[0], 2);
        chk("t6_arvalid", m_arvalid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_arvalid_rst", m_arvalid, 0);
        chk("t6_outst0_rst", dut.outst[0], 0);
        chk("t6_state_rst", dut.ar_state, AR_IDLE);

        // rlast for s0 with nothing outstanding: counter stays at 0
        m_rvalid = 1'b1; m_rid = 6'h00; m_rlast = 1'b1; s0_rready = 1'b1;
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        chk("t7_outst0_floor", dut.outst[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rocket_axi_rd_arbiter.md
# rocket_axi_rd_arbiter

Two-requester AXI4 read-channel arbiter that shares the Rocket core's 64-bit AXI master read port between the core memory port (requester 0) and the host boot/debug loader (requester 1). It sits between both requesters and the m_axi AR/R channels of the core wrapper. It prefixes each transaction ID with the requester index, routes R beats back by that prefix, and limits outstanding bursts per requester.

## Interface
- C_S_ID_WIDTH, 5, requester ID width; master ID width is C_S_ID_WIDTH+1 (6).
- C_ADDR_WIDTH, 32, address width.
- C_DATA_WIDTH, 64, data width.
- C_MAX_OUTSTANDING, 4, maximum outstanding bursts per requester (1..15).
- m_axi_aclk  in  1  sole clock; all logic is on its rising edge.
- m_axi_areset  in  1  synchronous, active-high reset.
- s0_arid / s0_araddr / s0_arlen / s0_arsize / s0_arburst / s0_arcache / s0_arprot  in  C_S_ID_WIDTH / C_ADDR_WIDTH / 8 / 3 / 2 / 4 / 3  requester 0 AR payload.
- s0_arvalid  in  1  requester 0 AR valid; s0_arready  out  1  AR accept.
- s0_rid / s0_rdata / s0_rresp / s0_rlast  out  C_S_ID_WIDTH / C_DATA_WIDTH / 2 / 1  R payload to requester 0.
- s0_rvalid  out  1  R valid; s0_rready  in  1  R accept.
- s1_*  identical set for requester 1.
- m_axi_arid / m_axi_araddr / m_axi_arlen / m_axi_arsize / m_axi_arburst / m_axi_arcache / m_axi_arprot  out  C_S_ID_WIDTH+1 / C_ADDR_WIDTH / 8 / 3 / 2 / 4 / 3  downstream AR payload; arid = {requester index, sN_arid}.
- m_axi_arvalid  out  1; m_axi_arready  in  1.
- m_axi_rid / m_axi_rdata / m_axi_rresp / m_axi_rlast / m_axi_rvalid  in  downstream R; m_axi_rready  out  1.

## Operation
- AR FSM, two states. IDLE: requester N is eligible when sN_arvalid=1 and outst_N < C_MAX_OUTSTANDING. The arbiter picks one eligible requester, drives sN_arready=1 for that cycle only, and captures the payload into the AR register. BUSY: m_axi_arvalid=1 with a stable payload; on m_axi_arready the FSM returns to IDLE and increments outst_N.
- Grant policy is round-robin: the last granted requester has lowest priority on the next contention (see Configuration). With a single eligible requester, it is granted.
- R routing is combinational, selected by m_axi_rid[C_S_ID_WIDTH]:
  - sN_rvalid = m_axi_rvalid & sel_N.
  - m_axi_rready = rready of the selected requester.
  - sN_rid = m_axi_rid[C_S_ID_WIDTH-1:0]; rdata, rresp and rlast are broadcast.
- outst_N is clog2(C_MAX_OUTSTANDING+1) bits. It decrements on an R handshake with rlast=1 for requester N.
  - Simultaneous increment and decrement for the same requester leaves it unchanged.
  - It saturates: never wraps below 0 or above C_MAX_OUTSTANDING.
- The non-selected requester's rvalid stays 0 while the other requester's beats are in flight. No reordering or buffering is performed.

## Timing
- Reset values: m_axi_arvalid=0, s0_arready=0, s1_arready=0, FSM=IDLE, outst_0=outst_1=0, round-robin pointer favours requester 0, AR register=0.
- sN_arready asserts in the same cycle as sN_arvalid when the FSM is IDLE and the requester is eligible and granted.
- m_axi_arvalid rises the following cycle. Best-case AR throughput is one request per 2 cycles.
- R path has zero-cycle latency and no registers.
- AR payload and m_axi_arvalid hold until m_axi_arready (AXI rule). sN_arready never depends on m_axi_arready.
- Reset mid-operation returns the FSM to IDLE and clears the counters. It discards in-flight state; the downstream slave is reset in the same cycle.

## Configuration
- RD_ARB_ROUND_ROBIN_EN defined: round-robin grant as above.
- RD_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins contention. The pointer register is not instantiated.

## Structure
- rocket_axi_pkg holds:
  - AXI burst constants (FIXED/INCR/WRAP) and resp constants (OKAY/EXOKAY/SLVERR/DECERR).
  - The AR FSM state enum (AR_IDLE, AR_BUSY).
  - The requester index constants.
- Sub-module rr_arbiter_2: two request inputs, an advance strobe, and a one-hot grant output. It contains the pointer register, and is compiled to fixed priority when RD_ARB_ROUND_ROBIN_EN is absent.

## Test plan
- s0 single AR, arid=5'h03, araddr=0x1000, arlen=3: m_axi_arid=6'h03 one cycle after s0_arready. 4 R beats with rid=6'h03 reach s0 only; outst_0 goes 0→1→0.
- s0 and s1 assert arvalid every cycle (round-robin build): grants alternate 0,1,0,1. In the fixed build, only s0 is granted while s0_arvalid=1.
- s1 issues 5 ARs with no R returned, C_MAX_OUTSTANDING=4: 4 accepted, the 5th waits with s1_arready=0 until an rlast for s1 is handshaken.
- m_axi_arready held 0 for 10 cycles: m_axi_arvalid and the payload stay stable. Neither s0_arready nor s1_arready asserts during the stall.
- Back-pressure on R: rid=6'h21 with s1_rready=0: m_axi_rready=0 and s0_rvalid=0. When s1_rready=1 the beat completes.
- Assert m_axi_areset while the FSM is BUSY with outst_0=2: the next cycle shows m_axi_arvalid=0, outst_0=0, FSM=IDLE.
